i2s_port_arb: RTL

- Arbiter and sequencer for the I2S register port. Two bus requesters share it: req 0 is the GPU/DSP side, req 1 is the 68k/host side.
- Converts a granted request into the timed register access the I2S block expects:
  - data driven on din[15:0];
  - one-hot write strobes i2s1w..i2s4w or read strobes i2s1r..i2s3r;
  - read data captured from dr_out.
- Sits between the bus-side register decode and the I2S serializer instance.

---
 rtl/i2s_arb_pkg.sv | 50 +++++
 rtl/i2s_rr_pick.sv | 22 ++
 rtl/i2s_port_arb.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_arb_pkg.sv
// i2s_arb_pkg: shared types and helpers for the I2S register-port arbiter.
//   state_e     - sequencer states (boot states only reachable with I2S_BOOTCFG_EN)
//   A_*         - register select codes on addr0/addr1
//   CNT_W       - width of the phase down-counter
//   strobe_enc  - {r3,r2,r1,w4,w3,w2,w1} one-hot strobe vector for a given access
package i2s_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_CAPT,
    S_DONE,
    S_BOOT0,
    S_BOOT1
  } state_e;

  localparam logic [1:0] A_LTXD  = 2'd0;
  localparam logic [1:0] A_RTXD  = 2'd1;
  localparam logic [1:0] A_SCLK  = 2'd2;
  localparam logic [1:0] A_SMODE = 2'd3;

  localparam int CNT_W = 2;

  // Bits [3:0] are write strobes for addr 0..3, bits [6:4] read strobes for
  // addr 0..2. A read of SMODE has no strobe and yields all zeros.
  function automatic logic [6:0] strobe_enc(input logic is_wr, input logic [1:0] a);
    logic [6:0] s;
    s = '0;
    if (is_wr) begin
      case (a)
        A_LTXD:  s[0] = 1'b1;
        A_RTXD:  s[1] = 1'b1;
        A_SCLK:  s[2] = 1'b1;
        A_SMODE: s[3] = 1'b1;
        default: s = '0;
      endcase
    end else begin
      case (a)
        A_LTXD:  s[4] = 1'b1;
        A_RTXD:  s[5] = 1'b1;
        A_SCLK:  s[6] = 1'b1;
        default: s = '0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/i2s_rr_pick.sv
// i2s_rr_pick: two-way round-robin picker, purely combinational.
//   i_req[1:0]  request levels
//   i_last      index of the previous winner
//   o_grant     one-hot grant (zero when nothing is requested)
//   o_win       winner index
module i2s_rr_pick
  import i2s_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_win
);

  // On contention the requester that did not win last time goes first.
  always_comb begin
    o_win = (i_req == 2'b11) ? ~i_last : i_req[1];
    o_grant = '0;
    if (i_req != 2'b00) o_grant[o_win] = 1'b1;
  end

endmodule

// File: rtl/i2s_port_arb.sv
// i2s_port_arb: arbitrates two bus requesters onto the I2S register port and
// sequences each access as setup -> strobe -> (read latency -> capture) -> ack.
//   clk, reset            clock, synchronous active-high reset
//   req/we[1:0]           request level and write(1)/read(0) per requester
//   addr0/1, wdata0/1     register select and write data per requester
//   ack[1:0], err, rdata  completion pulse, illegal/no-data flag, read result
//   busy                  sequencer not idle
//   din, i2s1w..i2s4w,
//   i2s1r..i2s3r          data and one-hot strobes to the I2S block
//   rd_data, rd_oe        I2S read bus and its output enable
// Optional macro I2S_BOOTCFG_EN: after reset, write BOOT_SCLK to SCLK and
// BOOT_SMODE to SMODE before serving any requester.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches the winner
// SETUP  | din driven, strobe low, SETUP_CYC cycles
// STROBE | one strobe high, STROBE_CYC cycles
// WAIT   | read latency, RD_LAT cycles
// CAPT   | sample rd_data/rd_oe into rdata/err
// DONE   | ack pulse to the winner
// BOOT0  | load boot SCLK write (boot build only)
// BOOT1  | load boot SMODE write (boot build only)
module i2s_port_arb
  import i2s_arb_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int RD_LAT     = 2
`ifdef I2S_BOOTCFG_EN
  ,
  parameter logic [15:0] BOOT_SCLK  = 16'h0013,
  parameter logic [15:0] BOOT_SMODE = 16'h0015
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] din,
  output logic        i2s1w,
  output logic        i2s2w,
  output logic        i2s3w,
  output logic        i2s4w,
  output logic        i2s1r,
  output logic        i2s2r,
  output logic        i2s3r,
  input  logic [15:0] rd_data,
  input  logic        rd_oe
);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_last, r_win, r_we, r_err;
  logic [1:0]         r_addr;
  logic [15:0]        r_wdata, r_rdata;
  logic [1:0]         w_grant;
  logic               w_win, w_valid, w_sel_we, w_illegal;
  logic [1:0]         w_sel_addr;
  logic [15:0]        w_sel_wdata;
  logic [6:0]         w_strb;
`ifdef I2S_BOOTCFG_EN
  logic               r_boot;
`endif

  i2s_rr_pick u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_win   (w_win)
  );

  assign w_valid     = |w_grant;
  assign w_sel_we    = we[w_win];
  assign w_sel_addr  = w_win ? addr1 : addr0;
  assign w_sel_wdata = w_win ? wdata1 : wdata0;
  assign w_illegal   = !w_sel_we && (w_sel_addr == A_SMODE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = (r_state != S_IDLE);
    din         = '0;
    w_strb      = '0;
    ack         = '0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          if (w_illegal) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          end
        end
      end
      S_SETUP: begin
        din = r_wdata;
        if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = CNT_W'(STROBE_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STROBE: begin
        din    = r_wdata;
        w_strb = strobe_enc(r_we, r_addr);
        if (r_cnt == '0) begin
          if (r_we) begin
            w_state_nxt = S_DONE;
`ifdef I2S_BOOTCFG_EN
            // Boot writes chain SCLK -> SMODE -> IDLE and never ack.
            if (r_boot) w_state_nxt = (r_addr == A_SCLK) ? S_BOOT1 : S_IDLE;
`endif
          end else if (RD_LAT == 0) begin
            w_state_nxt = S_CAPT;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(RD_LAT - 1);
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_CAPT;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_CAPT: w_state_nxt = S_DONE;
      S_DONE: begin
        ack[r_win]  = 1'b1;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end
`ifdef I2S_BOOTCFG_EN
      S_BOOT0, S_BOOT1: begin
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef I2S_BOOTCFG_EN
      r_state <= S_BOOT0;
      r_boot  <= 1'b0;
`else
      r_state <= S_IDLE;
`endif
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_last  <= w_win;
            r_win   <= w_win;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            // Reads keep din at zero through setup and strobe.
            r_wdata <= w_sel_we ? w_sel_wdata : '0;
            r_err   <= w_illegal;
            if (w_illegal) r_rdata <= '0;
`ifdef I2S_BOOTCFG_EN
            r_boot  <= 1'b0;
`endif
          end
        end
        S_CAPT: begin
          r_rdata <= rd_oe ? rd_data : '0;
          r_err   <= ~rd_oe;
        end
`ifdef I2S_BOOTCFG_EN
        S_BOOT0: begin
          r_boot  <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= A_SCLK;
          r_wdata <= BOOT_SCLK;
        end
        S_BOOT1: begin
          r_boot  <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= A_SMODE;
          r_wdata <= BOOT_SMODE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign {i2s3r, i2s2r, i2s1r, i2s4w, i2s3w, i2s2w, i2s1w} = w_strb;
  assign rdata = r_rdata;

endmodule
